// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered asynchronous serial transmitter.
// Frame: start bit, DATA_ bits LSB first, optional parity, STOP_ stop bits.
// tx and busy come straight from flops; the FIFO flags are pointer-derived.
module uart_tx #(
  parameter int    CLK_   = 50000000,
  parameter int    BAUD_  = 115200,
  parameter int    BUFF_  = 64,
  parameter int    DATA_  = 8,
  parameter int    STOP_  = 1,
  parameter string PARITY = "none"
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    wr_en,
  input  logic [DATA_-1:0]        wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(BUFF_):0]  level,
  output logic                    ovf,
  output logic                    busy,
  output logic                    tx
);

  localparam int DIV     = (CLK_ + BAUD_ / 2) / BAUD_;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(BUFF_);
  localparam int IW      = (DATA_ > 1) ? $clog2(DATA_) : 1;
  localparam bit HAS_PAR = (PARITY != "none");

  // Reject parameter sets the frame logic cannot honour.
  if (!(PARITY == "none" || PARITY == "even" || PARITY == "odd" ||
        PARITY == "mark" || PARITY == "space")) begin : g_bad_parity
    $error("uart_tx: PARITY must be none, even, odd, mark or space");
  end
  if (STOP_ != 1 && STOP_ != 2) begin : g_bad_stop
    $error("uart_tx: STOP_ must be 1 or 2");
  end
  if (DATA_ < 5 || DATA_ > 9) begin : g_bad_data
    $error("uart_tx: DATA_ must be 5..9");
  end
  if (BUFF_ < 2 || (BUFF_ & (BUFF_ - 1)) != 0) begin : g_bad_buff
    $error("uart_tx: BUFF_ must be a power of two >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP} state_t;

  // ---------------- FIFO ----------------
  logic [DATA_-1:0] mem [BUFF_];
  logic [AW:0]      wptr, rptr;
  logic [DATA_-1:0] head;
  logic             push, pop;
  state_t           state;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;
  assign head  = mem[rptr[AW-1:0]];
  // full is judged before the pop, so a write to a full FIFO always drops
  assign push  = wr_en && !full;
  assign pop   = (state == IDLE) && !empty;

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  end

  // Pointers and the overflow pulse.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      ovf <= wr_en && full;
    end
  end

  // ---------------- parity of the head word ----------------
  logic par_calc;

  // Parity bit for the word about to be popped.
  always_comb begin
    par_calc = 1'b0;
    if (PARITY == "even")      par_calc = ^head;
    else if (PARITY == "odd")  par_calc = ~^head;
    else if (PARITY == "mark") par_calc = 1'b1;
  end

  // ---------------- frame FSM ----------------
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic             sidx;
  logic [DATA_-1:0] shift;
  logic             par;
  logic             last;

  assign last = (cnt == CW'(DIV - 1));

  // Frame sequencer; tx/busy are loaded with the value of the state being entered.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sidx  <= 1'b0;
      shift <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shift <= head;
            par   <= par_calc;
            cnt   <= '0;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (last) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
            tx    <= shift[0];
          end else cnt <= cnt + 1'b1;
        end
        DATA: begin
          if (last) begin
            cnt   <= '0;
            shift <= shift >> 1;
            if (idx == IW'(DATA_ - 1)) begin
              if (HAS_PAR) begin
                state <= PAR_BIT;
                tx    <= par;
              end else begin
                state <= STOP;
                sidx  <= 1'b0;
                tx    <= 1'b1;
              end
            end else begin
              idx <= idx + 1'b1;
              tx  <= shift[1];
            end
          end else cnt <= cnt + 1'b1;
        end
        PAR_BIT: begin
          if (last) begin
            cnt   <= '0;
            sidx  <= 1'b0;
            state <= STOP;
            tx    <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        STOP: begin
          if (last) begin
            cnt <= '0;
            if (sidx == 1'(STOP_ - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              tx    <= 1'b1;
            end else sidx <= sidx + 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed + random frames against a bit-list frame model.
// Instance 0: no parity / 1 stop; 1..4: even/odd/mark/space; 5: no parity / 2 stops.
module tb_uart_tx;

  logic            clk = 1'b0;
  logic            rst_;
  logic [5:0]      wen;
  logic [7:0]      wd;
  wire  [5:0]      tx_v, busy_v, full_v, empty_v, ovf_v;
  wire  [5:0][2:0] lvl_v;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_(16), .BAUD_(1), .BUFF_(4), .DATA_(8), .STOP_(1), .PARITY("none")) u0 (
    .clk(clk), .rst_(rst_), .wr_en(wen[0]), .wr_data(wd), .full(full_v[0]), .empty(empty_v[0]),
    .level(lvl_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]), .tx(tx_v[0]));
  uart_tx #(.CLK_(16), .BAUD_(1), .BUFF_(4), .DATA_(8), .STOP_(1), .PARITY("even")) u1 (
    .clk(clk), .rst_(rst_), .wr_en(wen[1]), .wr_data(wd), .full(full_v[1]), .empty(empty_v[1]),
    .level(lvl_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]), .tx(tx_v[1]));
  uart_tx #(.CLK_(16), .BAUD_(1), .BUFF_(4), .DATA_(8), .STOP_(1), .PARITY("odd")) u2 (
    .clk(clk), .rst_(rst_), .wr_en(wen[2]), .wr_data(wd), .full(full_v[2]), .empty(empty_v[2]),
    .level(lvl_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]), .tx(tx_v[2]));
  uart_tx #(.CLK_(16), .BAUD_(1), .BUFF_(4), .DATA_(8), .STOP_(1), .PARITY("mark")) u3 (
    .clk(clk), .rst_(rst_), .wr_en(wen[3]), .wr_data(wd), .full(full_v[3]), .empty(empty_v[3]),
    .level(lvl_v[3]), .ovf(ovf_v[3]), .busy(busy_v[3]), .tx(tx_v[3]));
  uart_tx #(.CLK_(16), .BAUD_(1), .BUFF_(4), .DATA_(8), .STOP_(1), .PARITY("space")) u4 (
    .clk(clk), .rst_(rst_), .wr_en(wen[4]), .wr_data(wd), .full(full_v[4]), .empty(empty_v[4]),
    .level(lvl_v[4]), .ovf(ovf_v[4]), .busy(busy_v[4]), .tx(tx_v[4]));
  uart_tx #(.CLK_(16), .BAUD_(1), .BUFF_(4), .DATA_(8), .STOP_(2), .PARITY("none")) u5 (
    .clk(clk), .rst_(rst_), .wr_en(wen[5]), .wr_data(wd), .full(full_v[5]), .empty(empty_v[5]),
    .level(lvl_v[5]), .ovf(ovf_v[5]), .busy(busy_v[5]), .tx(tx_v[5]));

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line image of one frame: list of bit values, one per bit period.
  // par: 0 none, 1 even, 2 odd, 3 mark, 4 space.
  function automatic void model(input logic [7:0] d, input int par, input int nstop,
                                output logic [11:0] bits, output int nb);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (par != 0) begin
      case (par)
        1: bits[nb] = ($countones(d) % 2) == 1;
        2: bits[nb] = ($countones(d) % 2) == 0;
        3: bits[nb] = 1'b1;
        default: bits[nb] = 1'b0;
      endcase
      nb = nb + 1;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[nb] = 1'b1;
      nb = nb + 1;
    end
  endfunction

  task automatic wr1(input int s, input logic [7:0] d);
    wd = d;
    wen[s] = 1'b1;
    tick();
    wen = '0;
  endtask

  task automatic wait_busy(input int s);
    int n;
    n = 0;
    while (!busy_v[s] && n < 200) begin
      n++;
      tick();
    end
    chk("start_wait", busy_v[s], 1);
  endtask

  // Entered with the current sample at frame cycle c0; leaves on the first idle sample.
  task automatic frame(input int s, input logic [7:0] d, input int par, input int nstop,
                       input int c0, output logic [11:0] got, output int tail);
    logic [11:0] exp;
    int nb, c;
    model(d, par, nstop, exp, nb);
    got = '1;
    c = c0;
    tail = 0;
    while (busy_v[s] && c < 1000) begin
      if (c % 16 == 8 && c / 16 < 12) got[c/16] = tx_v[s];
      if (tx_v[s]) tail++;
      else tail = 0;
      c++;
      tick();
    end
    chk("frame_len", c, nb * 16);
    for (int k = 0; k < nb; k++) chk("frame_bit", got[k], exp[k]);
  endtask

  // Counts idle samples between frames; every one must show tx high.
  task automatic gap(input int s, output int n);
    int low;
    n = 0;
    low = 0;
    while (!busy_v[s] && n < 100) begin
      if (!tx_v[s]) low++;
      n++;
      tick();
    end
    chk("gap_tx_high", low, 0);
  endtask

  initial begin
    logic [11:0] got;
    logic [7:0]  d;
    logic [7:0]  dq[5];
    int          tail, n, cnt;
    int          pexp[5];

    pexp = '{0, 1, 0, 1, 0};
    rst_ = 1'b0;
    wen  = '0;
    wd   = '0;
    repeat (3) tick();
    chk("rst_tx", tx_v[0], 1);
    chk("rst_busy", busy_v[0], 0);
    chk("rst_full", full_v[0], 0);
    chk("rst_empty", empty_v[0], 1);
    chk("rst_level", lvl_v[0], 0);
    chk("rst_ovf", ovf_v[0], 0);
    rst_ = 1'b1;
    repeat (2) tick();

    // 0xA5: latency, mid-bit image, busy width
    wd = 8'hA5;
    wen[0] = 1'b1;
    tick();
    wen = '0;
    chk("lat_empty_fall", empty_v[0], 0);
    chk("lat_tx_still_high", tx_v[0], 1);
    chk("lat_busy_still_low", busy_v[0], 0);
    tick();
    chk("lat_tx_fall", tx_v[0], 0);
    chk("lat_busy_rise", busy_v[0], 1);
    frame(0, 8'hA5, 0, 1, 0, got, tail);
    chk("a5_image", got[9:0], 10'b11_0100_1010);

    // random single frames
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      wr1(0, d);
      wait_busy(0);
      frame(0, d, 0, 1, 0, got, tail);
      repeat (3) tick();
    end

    // back-to-back: queue 0x01..0x03 behind a running frame
    wr1(0, 8'h55);
    wait_busy(0);
    wen[0] = 1'b1;
    wd = 8'h01; tick();
    wd = 8'h02; tick();
    wd = 8'h03; tick();
    wen = '0;
    chk("b2b_level3", lvl_v[0], 3);
    frame(0, 8'h55, 0, 1, 3, got, tail);
    for (int i = 1; i <= 3; i++) begin
      gap(0, n);
      chk("b2b_gap", n, 1);
      chk("b2b_level_step", lvl_v[0], 3 - i);
      if (i == 3) chk("b2b_empty", empty_v[0], 1);
      frame(0, 8'(i), 0, 1, 0, got, tail);
    end
    cnt = 0;
    repeat (100) begin
      if (busy_v[0]) cnt++;
      tick();
    end
    chk("b2b_no_extra", cnt, 0);

    // overflow: five writes behind a running frame, fifth dropped
    d = 8'($urandom);
    wr1(0, d);
    wait_busy(0);
    for (int k = 0; k < 5; k++) begin
      dq[k] = 8'($urandom);
      wd = dq[k];
      wen[0] = 1'b1;
      tick();
      if (k == 3) begin
        chk("ovf_full", full_v[0], 1);
        chk("ovf_level4", lvl_v[0], 4);
        chk("ovf_not_yet", ovf_v[0], 0);
      end
    end
    wen = '0;
    chk("ovf_pulse", ovf_v[0], 1);
    chk("ovf_level_held", lvl_v[0], 4);
    tick();
    chk("ovf_one_cycle", ovf_v[0], 0);
    frame(0, d, 0, 1, 6, got, tail);
    for (int k = 0; k < 4; k++) begin
      gap(0, n);
      chk("ovf_gap", n, 1);
      frame(0, dq[k], 0, 1, 0, got, tail);
    end
    cnt = 0;
    repeat (200) begin
      if (busy_v[0]) cnt++;
      tick();
    end
    chk("ovf_dropped", cnt, 0);

    // parity flavours with 0x07, then a random byte each
    for (int s = 1; s <= 4; s++) begin
      wr1(s, 8'h07);
      wait_busy(s);
      frame(s, 8'h07, s, 1, 0, got, tail);
      chk("parity_07", got[9], pexp[s]);
      d = 8'($urandom);
      wr1(s, d);
      wait_busy(s);
      frame(s, d, s, 1, 0, got, tail);
    end

    // two stop bits: 0x00 then 0xFF, high time between them
    wd = 8'h00;
    wen[5] = 1'b1;
    tick();
    wd = 8'hFF;
    tick();
    wen = '0;
    wait_busy(5);
    frame(5, 8'h00, 0, 2, 0, got, tail);
    gap(5, n);
    chk("stop2_high", tail + n, 33);
    frame(5, 8'hFF, 0, 2, 0, got, tail);

    // reset in the middle of data bit 3, with another word queued
    wr1(0, 8'($urandom));
    wait_busy(0);
    wr1(0, 8'($urandom));
    repeat (71) tick();
    rst_ = 1'b0;
    #1;
    chk("mrst_tx", tx_v[0], 1);
    chk("mrst_busy", busy_v[0], 0);
    chk("mrst_level", lvl_v[0], 0);
    chk("mrst_empty", empty_v[0], 1);
    repeat (2) tick();
    rst_ = 1'b1;
    cnt = 0;
    repeat (200) begin
      if (busy_v[0] || !tx_v[0]) cnt++;
      tick();
    end
    chk("mrst_no_residual", cnt, 0);
    d = 8'($urandom);
    wr1(0, d);
    wait_busy(0);
    frame(0, d, 0, 1, 0, got, tail);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit engine for the MARVIN COM sector UART. It accepts bytes from the bus-side register logic through a write-strobe interface and buffers them in a FIFO. It serialises each byte onto `tx` as an asynchronous frame: start bit, DATA_ data bits LSB first, optional parity, STOP_ stop bits. Its line format and parameters match the receive side, so a `uart_tx` looped back into the UART receive path reproduces the written bytes.

## Interface
- CLK_, 50000000, system clock frequency in Hz
- BAUD_, 115200, line rate in bit/s
- BUFF_, 64, transmit FIFO depth in words; power of two, ≥ 2
- DATA_, 8, data bits per frame, 5..9
- STOP_, 1, stop bits per frame, 1 or 2
- PARITY, "none", one of "none", "even", "odd", "mark", "space"

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_  input  1  asynchronous, active-low reset
- wr_en  input  1  push `wr_data` into the FIFO this cycle
- wr_data  input  DATA_  byte to transmit
- full  output  1  FIFO holds BUFF_ entries
- empty  output  1  FIFO holds 0 entries
- level  output  $clog2(BUFF_)+1  current FIFO occupancy
- ovf  output  1  one-cycle pulse: a write was dropped because the FIFO was full
- busy  output  1  a frame is on the line (state ≠ IDLE)
- tx  output  1  serial line, idle high

## Operation
- Bit period DIV = (CLK_ + BAUD_/2) / BAUD_ cycles, rounded to nearest. The baud counter is $clog2(DIV) bits wide, counts 0..DIV-1, and is reset to 0 on every state entry.
- FIFO: circular buffer with read/write pointers one bit wider than the address; full/empty derive from pointer compare; `level` = wptr − rptr, modulo.
- Push: when `wr_en` and not `full`, write at wptr and increment wptr. When `wr_en` and `full`, drop the data and assert `ovf` for the next cycle only. `full` is judged before any same-cycle pop, so a write to a full FIFO is dropped even if a pop occurs that cycle.
- Simultaneous push and pop on a non-full FIFO: both take effect and `level` is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If not `empty`, load head word into the shift register, increment rptr, go to START.
  - START: `tx`=0 for DIV cycles, then DATA with bit index 0.
  - DATA: `tx`=shift[0] for DIV cycles. Then shift right and increment the index. After bit DATA_-1, go to PARITY if PARITY≠"none", else STOP.
  - PARITY: drive the parity bit for DIV cycles, then STOP. The parity bit is the XOR of the data bits for "even", its inverse for "odd", 1 for "mark", 0 for "space". It is computed from the popped word at load.
  - STOP: `tx`=1 for STOP_×DIV cycles, then IDLE.
- Back-to-back: if the FIFO is non-empty when STOP ends, IDLE lasts exactly one cycle (tx=1) before the next START.
- An invalid PARITY or STOP_ value is an elaboration error (`$error` in a generate check).

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) sets: `tx`=1, `busy`=0, `full`=0, `empty`=1, `level`=0, `ovf`=0, FSM=IDLE, both pointers 0, counters 0.
- Reset mid-frame aborts the frame immediately: `tx` goes high in the same instant and FIFO contents are discarded.
- Latency: `wr_en` sampled at edge N into an empty idle FIFO → `empty` falls after edge N. IDLE pops at edge N+1, so `tx` falls and `busy` rises after edge N+1.
- Frame length: (1 + DATA_ + (PARITY≠"none") + STOP_) × DIV cycles, plus 1 IDLE cycle between frames.
- `tx` is driven from a register; there is no combinational path from any input to `tx`.
- `full`, `empty` and `level` are registered or pointer-derived and update the cycle after the push or pop edge.

## Test plan
Bench parameters: CLK_=16, BAUD_=1 (DIV=16), BUFF_=4, DATA_=8, STOP_=1, PARITY="none".
- Write 0xA5 once → `tx` falls 2 edges after write. Sampling at mid-bit gives 0,1,0,1,0,0,1,0,1,1. `busy` stays high for 160 cycles.
- Write 0x01,0x02,0x03 in consecutive cycles → three frames separated by exactly 1 idle cycle. `level` reads 3, then steps 2,1,0 at each pop. `empty`=1 after the third pop.
- Write 5 words without transmit progress → `full`=1 at level 4. The 5th write pulses `ovf` for 1 cycle and is not transmitted. Exactly 4 frames appear.
- Rerun with PARITY="even", then "odd", "mark", "space", writing 0x07 each time → parity bits 1, 0, 1, 0 respectively; frame is 176 cycles.
- Rerun with STOP_=2, writing 0x00 then 0xFF → the high time between the two frames is 2×16+1 = 33 cycles.
- Assert `rst_`=0 in the middle of data bit 3 → `tx`=1, `busy`=0, `level`=0 immediately. After release, no residual frame is sent until a new write.
